// File: rtl/puf_pkg.sv
// Shared types and defaults for the PUF challenge/response evaluation controller.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SAMPLE,
    SETTLE,
    VOTE,
    REPORT,
    WAIT_REL
  } state_t;

  localparam int DEF_CHAL_W         = 8;
  localparam int DEF_RESP_W         = 8;
  localparam int DEF_EN_W           = 32;
  localparam int DEF_NUM_EVALS      = 5;
  localparam int DEF_SETTLE_CYCLES  = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Width needed to count 0..n inclusive.
  function automatic int CNT_W(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/puf_eval_ctrl_if.sv
// Host-side request/acknowledge bundle of the PUF evaluation controller.
// Optional macro PUF_STABILITY_MASK_EN adds the stable_mask response field.
interface puf_eval_ctrl_if
  import puf_pkg::*;
#(
  parameter int CHAL_W = DEF_CHAL_W,
  parameter int RESP_W = DEF_RESP_W
);
  logic              host_req;
  logic              host_ack;
  logic [CHAL_W-1:0] challenge_in;
  logic [RESP_W-1:0] resp_out;
  logic              resp_valid;
  logic              timeout_err;
`ifdef PUF_STABILITY_MASK_EN
  logic [RESP_W-1:0] stable_mask;
`endif

  modport master (
    output host_req, host_ack, challenge_in,
`ifdef PUF_STABILITY_MASK_EN
    input  stable_mask,
`endif
    input  resp_out, resp_valid, timeout_err
  );

  modport slave (
    input  host_req, host_ack, challenge_in,
`ifdef PUF_STABILITY_MASK_EN
    output stable_mask,
`endif
    output resp_out, resp_valid, timeout_err
  );
endinterface

// File: rtl/puf_sync2.sv
// Two-flop synchroniser for a single asynchronous control input.
module puf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end
endmodule

// File: rtl/puf_eval_ctrl.sv
// Challenge/response controller: runs NUM_EVALS PUF evaluations, majority-votes each bit.
// Optional macro PUF_STABILITY_MASK_EN adds a per-bit unanimity mask output.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int CHAL_W         = DEF_CHAL_W,
  parameter int RESP_W         = DEF_RESP_W,
  parameter int EN_W           = DEF_EN_W,
  parameter int NUM_EVALS      = DEF_NUM_EVALS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  puf_eval_ctrl_if.slave      host,
  input  logic                puf_done,
  input  logic [RESP_W-1:0]   puf_response,
  output logic [EN_W-1:0]     puf_enables,
  output logic [CHAL_W-1:0]   puf_challenge
);
  localparam int VCNT_W  = CNT_W(NUM_EVALS);
  localparam int CYC_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0]  TMO_LAST    = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]        EVAL_LAST   = 4'(NUM_EVALS - 1);
  localparam logic [VCNT_W:0]   NE_REF      = (VCNT_W + 1)'(NUM_EVALS);
  localparam logic [VCNT_W-1:0] NE_V        = VCNT_W'(NUM_EVALS);

  state_t              state;
  logic                req_s, ack_s, done_s, req_d;
  logic [3:0]          eval_cnt;
  logic [CYC_W-1:0]    cyc_cnt;
  logic [VCNT_W-1:0]   vote_cnt [RESP_W];
  logic                en_r, valid_r, tmo_r;
  logic [CHAL_W-1:0]   chal_r;
  logic [RESP_W-1:0]   resp_r;
  logic                start;

  puf_sync2 u_sync_req  (.clk(clk), .rst(rst), .d(host.host_req), .q(req_s));
  puf_sync2 u_sync_ack  (.clk(clk), .rst(rst), .d(host.host_ack), .q(ack_s));
  puf_sync2 u_sync_done (.clk(clk), .rst(rst), .d(puf_done),      .q(done_s));

  // Only a low-to-high request edge starts a run; a level left over from reset or abort does not.
  assign start = (state == IDLE) && req_s && !req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_d    <= 1'b0;
      eval_cnt <= '0;
      cyc_cnt  <= '0;
      en_r     <= 1'b0;
      valid_r  <= 1'b0;
      tmo_r    <= 1'b0;
      chal_r   <= '0;
      resp_r   <= '0;
      for (int i = 0; i < RESP_W; i++) vote_cnt[i] <= '0;
    end else begin
      req_d <= req_s;
      unique case (state)
        IDLE: if (start) begin
          // challenge_in is held steady by the host while host_req is high
          chal_r   <= host.challenge_in;
          resp_r   <= '0;
          tmo_r    <= 1'b0;
          eval_cnt <= '0;
          cyc_cnt  <= '0;
          for (int i = 0; i < RESP_W; i++) vote_cnt[i] <= '0;
          en_r     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (!req_s) begin
            en_r  <= 1'b0;
            state <= WAIT_REL;
          end else if (done_s) begin
            en_r  <= 1'b0;
            state <= SAMPLE;
          end else if (cyc_cnt == TMO_LAST) begin
            en_r    <= 1'b0;
            tmo_r   <= 1'b1;
            valid_r <= 1'b1;
            state   <= REPORT;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          for (int i = 0; i < RESP_W; i++)
            vote_cnt[i] <= vote_cnt[i] + VCNT_W'(puf_response[i]);
          eval_cnt <= eval_cnt + 1'b1;
          cyc_cnt  <= '0;
          state    <= (eval_cnt == EVAL_LAST) ? VOTE : SETTLE;
        end
        SETTLE: begin
          // Leave only once settle time has elapsed and the core has released done.
          if (!req_s) begin
            state <= WAIT_REL;
          end else if (cyc_cnt == SETTLE_LAST && !done_s) begin
            cyc_cnt <= '0;
            en_r    <= 1'b1;
            state   <= RUN;
          end else if (cyc_cnt != SETTLE_LAST) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        VOTE: begin
          for (int i = 0; i < RESP_W; i++)
            resp_r[i] <= ({vote_cnt[i], 1'b0} > NE_REF);
          valid_r <= 1'b1;
          state   <= REPORT;
        end
        REPORT: if (ack_s) begin
          valid_r <= 1'b0;
          state   <= WAIT_REL;
        end
        WAIT_REL: if (!req_s && !ack_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PUF_STABILITY_MASK_EN
  logic [RESP_W-1:0] mask_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_r <= '0;
    end else if (start) begin
      mask_r <= '0;
    end else if (state == VOTE) begin
      for (int i = 0; i < RESP_W; i++)
        mask_r[i] <= (vote_cnt[i] == '0) || (vote_cnt[i] == NE_V);
    end
  end

  assign host.stable_mask = mask_r;
`endif

  assign puf_enables      = {EN_W{en_r}};
  assign puf_challenge    = chal_r;
  assign host.resp_out    = resp_r;
  assign host.resp_valid  = valid_r;
  assign host.timeout_err = tmo_r;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: two instances (5 and 4 evaluations) driven by a behavioural PUF core.
module tb_puf_eval_ctrl;
  typedef struct packed {
    logic [7:0] resp;
    logic       tmo;
    logic [7:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  puf_eval_ctrl_if #(.CHAL_W(8), .RESP_W(8)) if_a ();
  puf_eval_ctrl_if #(.CHAL_W(8), .RESP_W(8)) if_b ();

  logic        req_v   [2];
  logic        ack_v   [2];
  logic [7:0]  chin_v  [2];
  logic        done_v  [2];
  logic [7:0]  presp_v [2];
  logic [31:0] en_o    [2];
  logic [7:0]  chal_o  [2];
  logic [7:0]  resp_o  [2];
  logic        rv_o    [2];
  logic        tmo_o   [2];
  logic [7:0]  mask_o  [2];
  logic [31:0] en_a, en_b;
  logic [7:0]  chal_a, chal_b;

  assign if_a.host_req = req_v[0];  assign if_a.host_ack = ack_v[0];  assign if_a.challenge_in = chin_v[0];
  assign if_b.host_req = req_v[1];  assign if_b.host_ack = ack_v[1];  assign if_b.challenge_in = chin_v[1];
  assign en_o[0] = en_a;  assign en_o[1] = en_b;
  assign chal_o[0] = chal_a;  assign chal_o[1] = chal_b;
  assign resp_o[0] = if_a.resp_out;  assign resp_o[1] = if_b.resp_out;
  assign rv_o[0] = if_a.resp_valid;  assign rv_o[1] = if_b.resp_valid;
  assign tmo_o[0] = if_a.timeout_err;  assign tmo_o[1] = if_b.timeout_err;
`ifdef PUF_STABILITY_MASK_EN
  assign mask_o[0] = if_a.stable_mask;  assign mask_o[1] = if_b.stable_mask;
`else
  assign mask_o[0] = 8'h00;  assign mask_o[1] = 8'h00;
`endif

  puf_eval_ctrl #(.CHAL_W(8), .RESP_W(8), .EN_W(32), .NUM_EVALS(5),
                  .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut_a (
    .clk(clk), .rst(rst), .host(if_a), .puf_done(done_v[0]),
    .puf_response(presp_v[0]), .puf_enables(en_a), .puf_challenge(chal_a));

  puf_eval_ctrl #(.CHAL_W(8), .RESP_W(8), .EN_W(32), .NUM_EVALS(4),
                  .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .rst(rst), .host(if_b), .puf_done(done_v[1]),
    .puf_response(presp_v[1]), .puf_enables(en_b), .puf_challenge(chal_b));

  int         checks = 0;
  int         errors = 0;
  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] vec    [2][16];
  int         idx    [2];
  int         dcnt   [2];
  int         pulses [2];
  logic       hang   [2];
  logic       en_prev[2];
  logic       rv_prev[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural core: done rises 3 cycles after enables go high, drops when enables fall.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en_o[d][0] && !en_prev[d]) pulses[d]++;
      en_prev[d] = en_o[d][0];
      if (!en_o[d][0]) begin
        done_v[d] = 1'b0;
        dcnt[d]   = 0;
      end else if (!done_v[d] && !hang[d]) begin
        if (dcnt[d] == 2) begin
          done_v[d]  = 1'b1;
          presp_v[d] = vec[d][idx[d] & 15];
          idx[d]++;
        end else begin
          dcnt[d]++;
        end
      end
    end
  end

  // Monitor: every rising resp_valid is matched against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rv_o[d] && !rv_prev[d]) begin
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_resp_valid_dut%0d", d), 32'd1, 32'd0);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("resp_out_dut%0d", d), 32'(resp_o[d]), 32'(e.resp));
          chk($sformatf("timeout_err_dut%0d", d), 32'(tmo_o[d]), 32'(e.tmo));
          chk($sformatf("enables_low_in_report_dut%0d", d), en_o[d], 32'h0);
`ifdef PUF_STABILITY_MASK_EN
          chk($sformatf("stable_mask_dut%0d", d), 32'(mask_o[d]), 32'(e.mask));
`endif
        end
      end
      rv_prev[d] = rv_o[d];
    end
  end

  task automatic fill_vec(input int d, input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3, input logic [7:0] v4);
    for (int i = 0; i < 16; i++) vec[d][i] = v0;
    vec[d][1] = v1; vec[d][2] = v2; vec[d][3] = v3; vec[d][4] = v4;
  endtask

  task automatic run_txn(input int d, input logic [7:0] c, input logic [7:0] er, input logic et,
                         input logic [7:0] em, input int ep, output int lat);
    exp_t e;
    int   n;
    e.resp = er; e.tmo = et; e.mask = em;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    idx[d] = 0; pulses[d] = 0;
    chin_v[d] = c; req_v[d] = 1'b1;
    n = 0;
    while (!rv_o[d] && n < 2000) begin @(negedge clk); n++; end
    lat = n;
    chk("resp_valid_within_budget", 32'(rv_o[d]), 32'd1);
    chk("puf_challenge", 32'(chal_o[d]), 32'(c));
    chk("enable_pulses", 32'(pulses[d]), 32'(ep));
    repeat (4) @(negedge clk);
    chk("resp_valid_held_until_ack", 32'(rv_o[d]), 32'd1);
    ack_v[d] = 1'b1;
    n = 0;
    while (rv_o[d] && n < 20) begin @(negedge clk); n++; end
    chk("resp_valid_drop_on_ack", 32'(rv_o[d]), 32'd0);
    req_v[d] = 1'b0; ack_v[d] = 1'b0;
    repeat (8) @(negedge clk);
    chk("resp_held_after_release", 32'(resp_o[d]), 32'(er));
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; ack_v[d] = 1'b0; chin_v[d] = 8'h00; done_v[d] = 1'b0; presp_v[d] = 8'h00;
      idx[d] = 0; dcnt[d] = 0; pulses[d] = 0; hang[d] = 1'b0; en_prev[d] = 1'b0; rv_prev[d] = 1'b0;
      for (int i = 0; i < 16; i++) vec[d][i] = 8'h00;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_enables", en_o[0], 32'h0);
    chk("reset_challenge", 32'(chal_o[0]), 32'h0);
    chk("reset_resp_out", 32'(resp_o[0]), 32'h0);
    chk("reset_resp_valid", 32'(rv_o[0]), 32'h0);
    chk("reset_timeout_err", 32'(tmo_o[0]), 32'h0);
    chk("reset_stable_mask", 32'(mask_o[0]), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Constant response
    fill_vec(0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    run_txn(0, 8'hA5, 8'h3C, 1'b0, 8'hFF, 5, lat);

    // Mixed responses, every bit set in 3 of 5
    fill_vec(0, 8'hFF, 8'h00, 8'hFF, 8'h0F, 8'hF0);
    run_txn(0, 8'hC3, 8'hFF, 1'b0, 8'h00, 5, lat);

    // Core never completes: timeout after 64 RUN cycles plus sync/start overhead
    hang[0] = 1'b1;
    run_txn(0, 8'h77, 8'h00, 1'b1, 8'h00, 1, lat);
    chk("timeout_latency_in_range", 32'(lat >= 64 && lat <= 72), 32'd1);
    hang[0] = 1'b0;

    // Abort during second RUN
    fill_vec(0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    idx[0] = 0; pulses[0] = 0;
    chin_v[0] = 8'h99; req_v[0] = 1'b1;
    n = 0;
    while (pulses[0] < 2 && n < 500) begin @(negedge clk); n++; end
    chk("abort_reached_second_run", 32'(pulses[0]), 32'd2);
    req_v[0] = 1'b0;
    n = 0;
    while (en_o[0] != 32'h0 && n < 20) begin @(negedge clk); n++; end
    chk("abort_enable_drop_cycles", 32'(n <= 3), 32'd1);
    repeat (12) @(negedge clk);
    chk("abort_no_resp_valid", 32'(rv_o[0]), 32'd0);
    chk("abort_no_timeout", 32'(tmo_o[0]), 32'd0);
    chk("abort_enables_stay_low", en_o[0], 32'h0);
    fill_vec(0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    run_txn(0, 8'h11, 8'h5A, 1'b0, 8'hFF, 5, lat);

    // Asynchronous reset while settling
    fill_vec(0, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    idx[0] = 0; pulses[0] = 0;
    chin_v[0] = 8'hA5; req_v[0] = 1'b1;
    n = 0;
    while (!(pulses[0] == 1 && en_o[0] == 32'h0) && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("pre_reset_challenge_latched", 32'(chal_o[0]), 32'hA5);
    #2;
    rst = 1'b1; req_v[0] = 1'b0;
    #1;
    chk("async_reset_enables", en_o[0], 32'h0);
    chk("async_reset_challenge", 32'(chal_o[0]), 32'h0);
    chk("async_reset_resp_valid", 32'(rv_o[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_txn(0, 8'hA5, 8'h3C, 1'b0, 8'hFF, 5, lat);

    // Four evaluations, bit 0 set in exactly two -> tie resolves to 0
    for (int i = 0; i < 16; i++) vec[1][i] = 8'h81;
    vec[1][2] = 8'h80; vec[1][3] = 8'hC0;
    run_txn(1, 8'h5A, 8'h80, 1'b0, 8'hBE, 4, lat);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/puf_eval_ctrl.md
Name: puf_eval_ctrl

Overview:
Parametrised challenge/response evaluation controller between the host handshake pins and a delay-based PUF core. Latches an N-bit challenge and drives the core's enable bus. Runs NUM_EVALS back-to-back evaluations and majority-votes each response bit. Presents the voted response under a four-phase req/ack handshake. Successor to the fixed 8-bit, single-shot serial wrapper: widths, evaluation count, settle time and timeout are all parameters.

Parameters:
CHAL_W, 8, challenge width in bits
RESP_W, 8, response width in bits
EN_W, 32, width of PUF enable bus
NUM_EVALS, 5, evaluations per challenge (1..15)
SETTLE_CYCLES, 16, cycles enables held low between evaluations
TIMEOUT_CYCLES, 4096, max cycles waiting for puf_done per evaluation

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
host_req  in  1  host request; challenge_in valid while high
host_ack  in  1  host acknowledge of response
challenge_in  in  CHAL_W  challenge from host pins
puf_done  in  1  core completion flag, asynchronous to clk
puf_response  in  RESP_W  raw core response, valid when puf_done high
puf_enables  out  EN_W  enable bus to core, all bits equal
puf_challenge  out  CHAL_W  latched challenge to core
resp_out  out  RESP_W  voted response
resp_valid  out  1  response/handshake done flag
timeout_err  out  1  evaluation timed out

Behaviour:
- Single clock, reset asynchronous and active-high. All outputs are 0 on reset. Counters are 0 and the FSM is in IDLE.
- host_req, host_ack and puf_done each pass through a 2-flop synchroniser before use, adding 2 cycles of latency.
- IDLE: on synchronised host_req=1, latch challenge_in into puf_challenge, clear the per-bit vote counters, eval_cnt=0 -> RUN.
- RUN: puf_enables all 1. Cycle counter increments each cycle.
  - sync puf_done=1 -> SAMPLE.
  - counter reaches TIMEOUT_CYCLES-1 -> set timeout_err, -> REPORT. No vote is applied; resp_out is 0.
- SAMPLE (1 cycle): for each bit i, vote_cnt[i] += puf_response[i]. eval_cnt++.
  - eval_cnt == NUM_EVALS-1 (before increment) -> VOTE.
  - otherwise -> SETTLE.
- SETTLE: puf_enables=0 for SETTLE_CYCLES cycles, then -> RUN.
  - SETTLE is also required to observe sync puf_done=0 before leaving. It waits past SETTLE_CYCLES if puf_done stays high.
- VOTE (1 cycle): resp_out[i] = (2*vote_cnt[i] > NUM_EVALS). Ties for even NUM_EVALS resolve to 0. -> REPORT.
- REPORT: puf_enables=0, resp_valid=1. Hold resp_out stable until sync host_ack=1 -> WAIT_REL.
- WAIT_REL: resp_valid=0. Wait until sync host_req=0 and host_ack=0 -> IDLE.
  - resp_out and timeout_err hold their values until the next IDLE->RUN. They clear on that transition.
- vote_cnt width is clog2(NUM_EVALS+1). The counter cannot overflow.
- host_req deasserted mid-evaluation (RUN/SETTLE) aborts: enables drop the same cycle it is detected, -> WAIT_REL, resp_valid stays 0.
- host_req still high on return to IDLE is not a new request. Only a low-then-high edge restarts.
- puf_done glitch shorter than 1 clk may be missed. RUN then times out, which is the defined outcome.
- Latency with an ideal core (puf_done immediate): about NUM_EVALS*(SETTLE_CYCLES+4)+6 cycles from req to resp_valid.

Optional Feature:
PUF_STABILITY_MASK_EN.
- Defined: adds output stable_mask[RESP_W], reset 0. It is updated in VOTE: bit i = 1 iff vote_cnt[i] is 0 or NUM_EVALS (unanimous). It is held and cleared with resp_out.
- Undefined: port absent, no extra logic.

Decomposition:
- Package puf_pkg holds:
  - FSM state enum (IDLE, RUN, SAMPLE, SETTLE, VOTE, REPORT, WAIT_REL).
  - CNT_W function (clog2).
  - Default width constants shared with the top level.
- Sub-module puf_sync2: generic 2-flop synchroniser with async active-high reset. Instantiated once per async input.

Test Plan:
1. NUM_EVALS=5, challenge 8'hA5, core returns 8'h3C every evaluation -> puf_challenge=8'hA5, resp_out=8'h3C, resp_valid high until ack, 5 enable pulses observed.
2. Responses 8'hFF, 8'h00, 8'hFF, 8'h0F, 8'hF0 -> resp_out=8'hFF (counts 3 per bit, 3>2.5). With PUF_STABILITY_MASK_EN, stable_mask=8'h00.
3. puf_done never asserted, TIMEOUT_CYCLES=64 -> timeout_err=1 at 64 cycles (+sync), resp_out=8'h00, resp_valid=1, enables low.
4. host_req dropped during second RUN -> enables low within 3 cycles, no resp_valid, FSM returns to IDLE. A next request with 8'h11 completes normally.
5. rst asserted in SETTLE -> all outputs 0 immediately (asynchronous), FSM IDLE. The next request behaves as in test 1.
6. NUM_EVALS=4, bit 0 high in exactly 2 of 4 evaluations -> resp_out[0]=0 (tie resolves to 0).
